// File: rtl/control_pkg.sv
// control_pkg: opcodes, control enums, D/E payload and ALU-decode helper for the pipelined control unit
package control_pkg;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_ctrl_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_src_t;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4, RES_IMM} result_src_t;
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    alu_ctrl_t   alu_ctrl;
    logic        alu_src;
    logic [2:0]  funct3;
  } ctrl_de_t;
  // SUB needs op[5] so that addi with imm bit 10 set still adds
  function automatic alu_ctrl_t alu_funct(input logic [2:0] f3, input logic f75, input logic op5);
    case (f3)
      3'b000:  return (f75 & op5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f75 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/pipe_main_decoder.sv
// pipe_main_decoder: combinational main + ALU decode for the D stage
// BRANCH_COND_EXT_EN: when undefined, funct3 1xx branches decode as illegal
module pipe_main_decoder
  import control_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output ctrl_de_t   ctrl,
  output imm_src_t   imm_src,
  output logic       illegal
);
  always_comb begin
    ctrl = '0;
    imm_src = IMM_I;
    illegal = 1'b0;
    ctrl.valid = 1'b1;
    ctrl.funct3 = funct3;
    case (op)
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_MEM;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src = 1'b1;
        imm_src = IMM_S;
      end
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl = alu_funct(funct3, funct7_5, op[5]);
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_ctrl = alu_funct(funct3, funct7_5, op[5]);
      end
      OP_B: begin
        ctrl.branch = 1'b1;
        ctrl.alu_ctrl = ALU_SUB;
        imm_src = IMM_B;
`ifndef BRANCH_COND_EXT_EN
        illegal = funct3[2];
`endif
      end
      OP_JAL: begin
        ctrl.jump = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        ctrl.jump = 1'b1;
        ctrl.jalr = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.result_src = RES_IMM;
        imm_src = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl = '0;
      imm_src = IMM_I;
    end
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: D-stage decode, D/E-E/M-M/W control pipeline and E-stage branch resolution
// BRANCH_COND_EXT_EN: enables blt/bge/bltu/bgeu; otherwise only beq/bne resolve
module pipelined_control_unit
  import control_pkg::*;
#(
  parameter int OP_WIDTH         = 7,
  parameter int FUNCT3_WIDTH     = 3,
  parameter int ALU_CTRL_WIDTH   = 4,
  parameter int IMM_SRC_WIDTH    = 3,
  parameter int RESULT_SRC_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [OP_WIDTH-1:0]         opD,
  input  logic [FUNCT3_WIDTH-1:0]     funct3D,
  input  logic                        funct7_5D,
  input  logic                        FlushE,
  input  logic                        ZeroE,
  input  logic                        NegE,
  input  logic                        CarryE,
  input  logic                        OverflowE,
  output logic [IMM_SRC_WIDTH-1:0]    ImmSrcD,
  output logic                        IllegalD,
  output logic [ALU_CTRL_WIDTH-1:0]   ALUControlE,
  output logic                        ALUSrcE,
  output logic                        JalrE,
  output logic                        PCSrcE,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcE,
  output logic                        MemWriteM,
  output logic                        RegWriteM,
  output logic                        RegWriteW,
  output logic [RESULT_SRC_WIDTH-1:0] ResultSrcW,
  output logic                        ValidW
);
  ctrl_de_t ctrl_d, de_q;
  imm_src_t imm_src_d;
  logic valid_m, valid_w, mem_write_m, reg_write_m, reg_write_w, cond;
  result_src_t result_src_m, result_src_w;
  pipe_main_decoder u_dec (
    .op(opD),
    .funct3(funct3D),
    .funct7_5(funct7_5D),
    .ctrl(ctrl_d),
    .imm_src(imm_src_d),
    .illegal(IllegalD)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= '0;
      valid_m <= 1'b0;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
      result_src_m <= RES_ALU;
      valid_w <= 1'b0;
      reg_write_w <= 1'b0;
      result_src_w <= RES_ALU;
    end else begin
      de_q <= FlushE ? '0 : ctrl_d;
      valid_m <= de_q.valid;
      reg_write_m <= de_q.reg_write;
      mem_write_m <= de_q.mem_write;
      result_src_m <= de_q.result_src;
      valid_w <= valid_m;
      reg_write_w <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end
  always_comb begin
    cond = 1'b0;
    case (de_q.funct3)
      3'b000: cond = ZeroE;
      3'b001: cond = ~ZeroE;
`ifdef BRANCH_COND_EXT_EN
      3'b100: cond = NegE ^ OverflowE;
      3'b101: cond = ~(NegE ^ OverflowE);
      3'b110: cond = ~CarryE;
      3'b111: cond = CarryE;
`endif
      default: cond = 1'b0;
    endcase
  end
`ifndef BRANCH_COND_EXT_EN
  logic unused_flags;
  assign unused_flags = ^{NegE, CarryE, OverflowE};
`endif
  assign PCSrcE = de_q.valid & (de_q.jump | (de_q.branch & cond));
  assign ImmSrcD = imm_src_d;
  assign ALUControlE = de_q.alu_ctrl;
  assign ALUSrcE = de_q.alu_src;
  assign JalrE = de_q.jalr;
  assign ResultSrcE = de_q.result_src;
  assign MemWriteM = mem_write_m;
  assign RegWriteM = reg_write_m;
  assign RegWriteW = reg_write_w;
  assign ResultSrcW = result_src_w;
  assign ValidW = valid_w;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: table-driven decode/pipeline vectors plus flush and reset sequences
module tb_pipelined_control_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opD = 7'd0;
  logic [2:0] funct3D = 3'd0;
  logic funct7_5D = 1'b0, FlushE = 1'b0;
  logic ZeroE = 1'b0, NegE = 1'b0, CarryE = 1'b0, OverflowE = 1'b0;
  logic [2:0] ImmSrcD;
  logic IllegalD, ALUSrcE, JalrE, PCSrcE, MemWriteM, RegWriteM, RegWriteW, ValidW;
  logic [3:0] ALUControlE;
  logic [1:0] ResultSrcE, ResultSrcW;
  int n_vec = 0, n_bad = 0;

  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7_5D(funct7_5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE), .OverflowE(OverflowE),
    .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .JalrE(JalrE), .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ValidW(ValidW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f75;
    logic [3:0] zncv;
    logic       ill;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       asrc, jalr, pcsrc;
    logic [1:0] rsrc;
    logic       mw, rw, v;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    opD = op;
    funct3D = f3;
    funct7_5D = f75;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " ALUControlE"}, int'(ALUControlE), 0);
    chk({tag, " ALUSrcE"}, int'(ALUSrcE), 0);
    chk({tag, " JalrE"}, int'(JalrE), 0);
    chk({tag, " PCSrcE"}, int'(PCSrcE), 0);
    chk({tag, " ResultSrcE"}, int'(ResultSrcE), 0);
    chk({tag, " MemWriteM"}, int'(MemWriteM), 0);
    chk({tag, " RegWriteM"}, int'(RegWriteM), 0);
    chk({tag, " RegWriteW"}, int'(RegWriteW), 0);
    chk({tag, " ResultSrcW"}, int'(ResultSrcW), 0);
    chk({tag, " ValidW"}, int'(ValidW), 0);
  endtask

  initial begin
    //            op          f3    f75  zncv    ill imm alu asrc jalr pc rsrc mw rw v
    tbl[0]  = '{7'b0110011, 3'b000, 1'b1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
    tbl[1]  = '{7'b0110011, 3'b000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{7'b0010011, 3'b000, 1'b1, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{7'b0010011, 3'b101, 1'b1, 4'b0000, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1};
    tbl[4]  = '{7'b0110011, 3'b101, 1'b0, 4'b0000, 0, 0, 8, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{7'b0110011, 3'b111, 1'b0, 4'b0000, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{7'b0110011, 3'b011, 1'b0, 4'b0000, 0, 0, 6, 0, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{7'b0000011, 3'b010, 1'b0, 4'b0000, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1};
    tbl[8]  = '{7'b0100011, 3'b010, 1'b0, 4'b0000, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
    tbl[9]  = '{7'b1100011, 3'b000, 1'b0, 4'b1000, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[10] = '{7'b1100011, 3'b000, 1'b0, 4'b0000, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{7'b1100011, 3'b001, 1'b0, 4'b0000, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
`ifdef BRANCH_COND_EXT_EN
    tbl[12] = '{7'b1100011, 3'b110, 1'b0, 4'b0000, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[13] = '{7'b1100011, 3'b100, 1'b0, 4'b0100, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[14] = '{7'b1100011, 3'b101, 1'b0, 4'b0101, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[15] = '{7'b1100011, 3'b111, 1'b0, 4'b0010, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1};
`else
    tbl[12] = '{7'b1100011, 3'b110, 1'b0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{7'b1100011, 3'b100, 1'b0, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{7'b1100011, 3'b101, 1'b0, 4'b0101, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{7'b1100011, 3'b111, 1'b0, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    tbl[16] = '{7'b1101111, 3'b000, 1'b0, 4'b0000, 0, 3, 0, 0, 0, 1, 2, 0, 1, 1};
    tbl[17] = '{7'b1100111, 3'b000, 1'b0, 4'b0000, 0, 0, 0, 1, 1, 1, 2, 0, 1, 1};
    tbl[18] = '{7'b0110111, 3'b000, 1'b0, 4'b1111, 0, 4, 0, 0, 0, 0, 3, 0, 1, 1};
    tbl[19] = '{7'b0001111, 3'b000, 1'b0, 4'b1000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    #2;
    all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(tbl[i].op, tbl[i].f3, tbl[i].f75);
      {ZeroE, NegE, CarryE, OverflowE} = tbl[i].zncv;
      #1;
      chk({t, " IllegalD"}, int'(IllegalD), int'(tbl[i].ill));
      chk({t, " ImmSrcD"}, int'(ImmSrcD), int'(tbl[i].imm));
      @(negedge clk);
      drive(7'd0, 3'd0, 1'b0);
      chk({t, " ALUControlE"}, int'(ALUControlE), int'(tbl[i].alu));
      chk({t, " ALUSrcE"}, int'(ALUSrcE), int'(tbl[i].asrc));
      chk({t, " JalrE"}, int'(JalrE), int'(tbl[i].jalr));
      chk({t, " PCSrcE"}, int'(PCSrcE), int'(tbl[i].pcsrc));
      chk({t, " ResultSrcE"}, int'(ResultSrcE), int'(tbl[i].rsrc));
      @(negedge clk);
      chk({t, " MemWriteM"}, int'(MemWriteM), int'(tbl[i].mw));
      chk({t, " RegWriteM"}, int'(RegWriteM), int'(tbl[i].rw));
      @(negedge clk);
      chk({t, " RegWriteW"}, int'(RegWriteW), int'(tbl[i].rw));
      chk({t, " ResultSrcW"}, int'(ResultSrcW), int'(tbl[i].rsrc));
      chk({t, " ValidW"}, int'(ValidW), int'(tbl[i].v));
      @(negedge clk);
    end

    {ZeroE, NegE, CarryE, OverflowE} = 4'b0000;
    drive(7'b0000011, 3'b010, 1'b0);
    @(negedge clk);
    chk("lw ResultSrcE", int'(ResultSrcE), 1);
    drive(7'b0110011, 3'b000, 1'b1);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    drive(7'd0, 3'd0, 1'b0);
    chk("bubble ResultSrcE", int'(ResultSrcE), 0);
    chk("bubble ALUControlE", int'(ALUControlE), 0);
    chk("bubble ALUSrcE", int'(ALUSrcE), 0);
    chk("bubble PCSrcE", int'(PCSrcE), 0);
    chk("lw RegWriteM", int'(RegWriteM), 1);
    chk("lw MemWriteM", int'(MemWriteM), 0);
    @(negedge clk);
    chk("lw RegWriteW", int'(RegWriteW), 1);
    chk("lw ResultSrcW", int'(ResultSrcW), 1);
    chk("lw ValidW", int'(ValidW), 1);
    chk("bubble RegWriteM", int'(RegWriteM), 0);
    @(negedge clk);
    @(negedge clk);

    drive(7'b1101111, 3'd0, 1'b0);
    FlushE = 1'b1;
    @(negedge clk);
    chk("flush1 PCSrcE", int'(PCSrcE), 0);
    drive(7'b0001111, 3'd0, 1'b0);
    @(negedge clk);
    chk("flush2 PCSrcE", int'(PCSrcE), 0);
    FlushE = 1'b0;
    drive(7'd0, 3'd0, 1'b0);
    @(negedge clk);
    chk("flush2 RegWriteM", int'(RegWriteM), 0);
    @(negedge clk);
    chk("flush ValidW a", int'(ValidW), 0);
    @(negedge clk);
    chk("flush ValidW b", int'(ValidW), 0);

    drive(7'b0110011, 3'd0, 1'b0);
    @(negedge clk);
    drive(7'b0000011, 3'b010, 1'b0);
    @(negedge clk);
    drive(7'b1101111, 3'd0, 1'b0);
    @(negedge clk);
    drive(7'd0, 3'd0, 1'b0);
    chk("pre-reset PCSrcE", int'(PCSrcE), 1);
    chk("pre-reset RegWriteM", int'(RegWriteM), 1);
    chk("pre-reset ValidW", int'(ValidW), 1);
    #2;
    rst_n = 1'b0;
    #1;
    all_zero("mid reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(7'b0110011, 3'b000, 1'b1);
    @(negedge clk);
    drive(7'd0, 3'd0, 1'b0);
    chk("post-reset ALUControlE", int'(ALUControlE), 1);
    chk("post-reset ValidW 1", int'(ValidW), 0);
    @(negedge clk);
    chk("post-reset RegWriteM", int'(RegWriteM), 1);
    chk("post-reset ValidW 2", int'(ValidW), 0);
    @(negedge clk);
    chk("post-reset RegWriteW", int'(RegWriteW), 1);
    chk("post-reset ValidW 3", int'(ValidW), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

- Five-stage successor to the single-cycle control unit.
- Decodes the instruction in Decode (D) and carries control fields through the D/E, E/M and M/W pipeline registers, with flush support.
- Resolves branches and jumps in Execute (E) from the full ALU flag set.
- Sits between the datapath's instruction register and the hazard unit, and exports the stage-tagged signals the hazard unit needs.

## Interface

Parameters:
- OP_WIDTH, 7, opcode width
- FUNCT3_WIDTH, 3, funct3 width
- ALU_CTRL_WIDTH, 4, ALU control code width
- IMM_SRC_WIDTH, 3, immediate-format select width
- RESULT_SRC_WIDTH, 2, writeback mux select width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- opD  in  OP_WIDTH  opcode of instruction in D
- funct3D  in  FUNCT3_WIDTH  funct3 in D
- funct7_5D  in  1  instruction bit 30 in D
- FlushE  in  1  from hazard unit; load a bubble into D/E
- ZeroE, NegE, CarryE, OverflowE  in  1 each  ALU flags of rs1−rs2 in E
- ImmSrcD  out  IMM_SRC_WIDTH  combinational, D stage
- IllegalD  out  1  opcode unsupported, D stage
- ALUControlE  out  ALU_CTRL_WIDTH  registered
- ALUSrcE  out  1  registered
- JalrE  out  1  PC target base = rs1 (else PC)
- PCSrcE  out  1  redirect fetch
- ResultSrcE  out  RESULT_SRC_WIDTH  for load-use detection
- MemWriteM  out  1
- RegWriteM  out  1
- RegWriteW  out  1
- ResultSrcW  out  RESULT_SRC_WIDTH
- ValidW  out  1  a real instruction retires this cycle

## Operation

**Decode (combinational in D)**
- lw 0000011: RegWrite, ALUSrc, ImmSrc I, ResultSrc 01, ALUOp add.
- sw 0100011: MemWrite, ALUSrc, ImmSrc S, ALUOp add.
- R 0110011: RegWrite, ALUOp funct.
- I-ALU 0010011: RegWrite, ALUSrc, ImmSrc I, ALUOp funct.
- branch 1100011: Branch, ImmSrc B, ALUOp sub.
- jal 1101111: Jump, RegWrite, ImmSrc J, ResultSrc 10.
- jalr 1100111: Jump, Jalr, RegWrite, ALUSrc, ImmSrc I, ResultSrc 10.
- lui 0110111: RegWrite, ImmSrc U, ResultSrc 11 (ImmExt).
- Any other opcode: IllegalD=1, all control fields 0, Valid=0.

**ALU decode**
- Codes come from the package: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
- SUB is selected only when funct3=000, funct7_5=1 and opD[5]=1.
- SRA is selected for funct3=101 with funct7_5=1, for both R and I forms.

**Pipeline registers**
- D/E holds: Valid, RegWrite, ResultSrc, MemWrite, Branch, Jump, Jalr, ALUControl, ALUSrc, funct3.
- E/M holds: Valid, RegWrite, ResultSrc, MemWrite.
- M/W holds: Valid, RegWrite, ResultSrc.
- Every register advances each clock; there is no stall input, because a D-stall is realised by the hazard unit as FlushE.
- FlushE=1 clears D/E to all-zero at the next edge.
- FlushE has no effect on E/M or M/W. The instruction already in E still advances.

**Branch resolution in E**
- PCSrcE = ValidE & (JumpE | (BranchE & cond)).
- cond by funct3E:
  - 000 beq: Z
  - 001 bne: ~Z
  - 100 blt: N^V
  - 101 bge: ~(N^V)
  - 110 bltu: ~C
  - 111 bgeu: C
  - other: 0
- The block does not flush itself on a taken branch; the hazard unit asserts FlushE in response to PCSrcE.

## Timing

- Decode outputs (ImmSrcD, IllegalD) are pure combinational.
- E outputs appear 1 cycle after the instruction is in D, M outputs after 2 cycles, W outputs after 3 cycles.
- PCSrcE is combinational from D/E register contents and the E flags, valid in the same cycle the flags are.
- Reset (async, rst_n=0): all pipeline registers clear immediately, so every registered output and PCSrcE is 0.
- Release of reset is synchronous to clk.
- Reset mid-stream discards all in-flight instructions; no retire is reported.
- FlushE together with an illegal opcode in D: D/E loads zero either way.
- Back-to-back flushes each insert one bubble.

## Configuration

- BRANCH_COND_EXT_EN defined: all six branch conditions above are supported.
- BRANCH_COND_EXT_EN undefined: only beq and bne are supported. funct3 1xx branches resolve not-taken, and IllegalD is asserted for them in D.

## Structure

- Shared package `control_pkg` holds:
  - opcode localparams
  - alu_ctrl_t enum
  - imm_src_t and result_src_t enums
  - packed struct ctrl_de_t for the D/E payload
- Sub-module `pipe_main_decoder` contains the combined main and ALU decode, purely combinational.
- The top module holds the three pipeline registers and the branch-resolution logic.

## Test plan

- R-type sub (opD=0110011, funct3=000, funct7_5=1) → ALUControlE=SUB at cycle 1, RegWriteM=1 at cycle 2, RegWriteW=1 and ValidW=1 at cycle 3.
- beq in E with ZeroE=1 → PCSrcE=1; with ZeroE=0 → PCSrcE=0. bltu with CarryE=0 → PCSrcE=1.
- lw followed by FlushE=1 → ResultSrcE=01 for one cycle, then the bubble gives all E outputs 0, while MemWriteM/RegWriteM of the lw still propagate.
- jalr → JalrE=1, PCSrcE=1 regardless of flags, ResultSrcW=10 three cycles later.
- Opcode 0001111 → IllegalD=1 and ValidW=0 three cycles later. With BRANCH_COND_EXT_EN undefined, blt gives IllegalD=1 and PCSrcE=0.
- rst_n pulled low mid-stream with 3 instructions in flight → all outputs 0 immediately; after release, the first new instruction reaches W after 3 cycles.
